memory_map_router: RTL and testbench

Parametrised successor to the single-UART memory map controller: routes one host command port (CPU memory interface) to NUM_TARGETS memory-mapped slaves by base/mask decode. Adds a registered transaction tracker, so read data is returned from the target that accepted the command even if `input_addr` changes afterwards. Also adds an error response for unmapped addresses and a per-read timeout. Sits between the core's memory stage and RAM/UART/other MMIO blocks.

---
 rtl/memory_map_router.sv | 203 ++++++++++++++++++++
 tb/tb_memory_map_router.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_map_router.sv
// memory_map_router
//   Routes one host command port to NUM_TARGETS memory-mapped slaves using a
//   base/mask address decode. A read is tracked by the index of the target
//   that accepted it, so the reply path ignores later input_addr changes.
//   Unmapped reads and read timeouts get an error reply carrying ERROR_DATA.
//   Unmapped writes are dropped and flagged with a one-cycle pulse.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   input_cmd_start/write   host command request and direction (1 = write)
//   output_cmd_ready        router accepts a command this cycle
//   input_addr/wdata        host byte address and write data
//   output_rdata(_valid)    read reply to the host, one-cycle strobe
//   output_error            qualifies rdata_valid: unmapped read or timeout
//   output_unmapped_write   pulse: an unmapped write was dropped
//   tgt_cmd_start/write     per-target command strobe and direction
//   tgt_cmd_ready           per-target ready
//   tgt_addr                per-target offset address (input_addr - base_i)
//   tgt_wdata               shared write data
//   tgt_rdata(_valid)       per-target read data and strobe
module memory_map_router #(
  parameter int unsigned NUM_TARGETS = 2,
  parameter logic [NUM_TARGETS*32-1:0] TARGET_BASE = {32'hff000000, 32'h00000000},
  parameter logic [NUM_TARGETS*32-1:0] TARGET_MASK = {32'hfffffe00, 32'hfffff000},
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ERROR_DATA = 32'hdeadbeef
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      input_cmd_start,
  input  logic                      input_cmd_write,
  output logic                      output_cmd_ready,
  input  logic [31:0]               input_addr,
  input  logic [31:0]               input_wdata,
  output logic [31:0]               output_rdata,
  output logic                      output_rdata_valid,
  output logic                      output_error,
  output logic                      output_unmapped_write,
  output logic [NUM_TARGETS-1:0]    tgt_cmd_start,
  output logic [NUM_TARGETS-1:0]    tgt_cmd_write,
  input  logic [NUM_TARGETS-1:0]    tgt_cmd_ready,
  output logic [NUM_TARGETS*32-1:0] tgt_addr,
  output logic [31:0]               tgt_wdata,
  input  logic [NUM_TARGETS*32-1:0] tgt_rdata,
  input  logic [NUM_TARGETS-1:0]    tgt_rdata_valid
);

  localparam int unsigned SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t             state_r;
  logic [15:0]        count_r;
  logic [SEL_W-1:0]   cur_r;
  logic               unmapped_write_r;

  logic [NUM_TARGETS-1:0] hit_s;
  logic [SEL_W-1:0]       sel_s;
  logic                   mapped_s;
  logic                   sel_ready_s;
  logic                   cur_valid_s;
  logic [31:0]            cur_rdata_s;
  logic                   idle_s;
  logic                   accept_s;

  // Address decode: per-target hit, lowest hit index wins on overlap.
  always_comb begin
    hit_s = '0;
    sel_s = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      hit_s[i] = ((input_addr & TARGET_MASK[32*i +: 32]) == TARGET_BASE[32*i +: 32]);
    end
    // Scan downward so the last assignment is the lowest hit index.
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        sel_s = SEL_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
    mapped_s = |hit_s;
  end

  // Ready of the decoded target and reply signals of the tracked target.
  always_comb begin
    sel_ready_s = 1'b0;
    cur_valid_s = 1'b0;
    cur_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_s == SEL_W'(i)) begin
        sel_ready_s = tgt_cmd_ready[i];
      end else begin
        sel_ready_s = sel_ready_s;
      end
      if (cur_r == SEL_W'(i)) begin
        cur_valid_s = tgt_rdata_valid[i];
        cur_rdata_s = tgt_rdata[32*i +: 32];
      end else begin
        cur_valid_s = cur_valid_s;
        cur_rdata_s = cur_rdata_s;
      end
    end
  end

  assign idle_s   = (state_r == IDLE);
  assign accept_s = input_cmd_start && output_cmd_ready;

  // Per-target command fan-out; start is gated by decode only, not by ready.
  always_comb begin
    tgt_cmd_start = '0;
    tgt_cmd_write = '0;
    tgt_addr      = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      tgt_cmd_start[i] = input_cmd_start && idle_s && mapped_s && (sel_s == SEL_W'(i));
      tgt_cmd_write[i] = input_cmd_start && idle_s && mapped_s && (sel_s == SEL_W'(i))
                         && input_cmd_write;
      tgt_addr[32*i +: 32] = input_addr - TARGET_BASE[32*i +: 32];
    end
  end

  assign tgt_wdata = input_wdata;

  // Host-side reply: read data is forwarded in the same cycle the target strobes.
  always_comb begin
    output_cmd_ready   = 1'b0;
    output_rdata       = 32'h0000_0000;
    output_rdata_valid = 1'b0;
    output_error       = 1'b0;
    case (state_r)
      IDLE: begin
        output_cmd_ready = mapped_s ? sel_ready_s : 1'b1;
      end
      BUSY: begin
        if (cur_valid_s) begin
          output_rdata       = cur_rdata_s;
          output_rdata_valid = 1'b1;
        end else begin
          output_rdata_valid = 1'b0;
        end
      end
      ERR: begin
        output_rdata       = ERROR_DATA;
        output_rdata_valid = 1'b1;
        output_error       = 1'b1;
      end
      default: begin
        output_cmd_ready = 1'b0;
      end
    endcase
  end

  assign output_unmapped_write = unmapped_write_r;

  // Transaction tracker FSM: outstanding-read target, timeout counter, write-drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      count_r          <= 16'd0;
      cur_r            <= '0;
      unmapped_write_r <= 1'b0;
    end else begin
      unmapped_write_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && input_cmd_write) begin
            unmapped_write_r <= !mapped_s;
          end else if (accept_s && mapped_s) begin
            cur_r   <= sel_s;
            count_r <= 16'd0;
            state_r <= BUSY;
          end else if (accept_s) begin
            state_r <= ERR;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cur_valid_s) begin
            state_r <= IDLE;
          end else if (count_r == TIMEOUT_LAST) begin
            state_r <= ERR;
          end else if (count_r != 16'hffff) begin
            count_r <= count_r + 16'd1;
          end else begin
            count_r <= count_r;
          end
        end
        ERR: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_map_router.sv
// Testbench for memory_map_router: a table of combinational decode vectors
// followed by hand-written multi-cycle sequences (read latency, back-to-back
// writes, unmapped access, timeout, foreign-target valids, reset mid-read).
// Target 0 is mapped at 0xff000000/0xfffffe00, target 1 at 0x0/0xfffff000.
module tb_memory_map_router;

  logic        clk;
  logic        rst_n;
  logic        input_cmd_start;
  logic        input_cmd_write;
  logic        output_cmd_ready;
  logic [31:0] input_addr;
  logic [31:0] input_wdata;
  logic [31:0] output_rdata;
  logic        output_rdata_valid;
  logic        output_error;
  logic        output_unmapped_write;
  logic [1:0]  tgt_cmd_start;
  logic [1:0]  tgt_cmd_write;
  logic [1:0]  tgt_cmd_ready;
  logic [63:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [63:0] tgt_rdata;
  logic [1:0]  tgt_rdata_valid;

  int checks;
  int errors;

  memory_map_router #(
    .NUM_TARGETS(2),
    .TARGET_BASE({32'h00000000, 32'hff000000}),
    .TARGET_MASK({32'hfffff000, 32'hfffffe00}),
    .TIMEOUT(4),
    .ERROR_DATA(32'hdeadbeef)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .input_cmd_start(input_cmd_start),
    .input_cmd_write(input_cmd_write),
    .output_cmd_ready(output_cmd_ready),
    .input_addr(input_addr),
    .input_wdata(input_wdata),
    .output_rdata(output_rdata),
    .output_rdata_valid(output_rdata_valid),
    .output_error(output_error),
    .output_unmapped_write(output_unmapped_write),
    .tgt_cmd_start(tgt_cmd_start),
    .tgt_cmd_write(tgt_cmd_write),
    .tgt_cmd_ready(tgt_cmd_ready),
    .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata),
    .tgt_rdata(tgt_rdata),
    .tgt_rdata_valid(tgt_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        start;
    logic        write;
    logic [1:0]  rdy;
    logic        exp_ready;
    logic [1:0]  exp_start;
    logic [1:0]  exp_write;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{32'hff000004, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b01, 32'h00000004, 32'hff000004};
    vecs[1] = '{32'h00000010, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 32'h01000010, 32'h00000010};
    vecs[2] = '{32'h00000010, 1'b1, 1'b0, 2'b01, 1'b0, 2'b10, 2'b00, 32'h01000010, 32'h00000010};
    vecs[3] = '{32'h80000000, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 32'h81000000, 32'h80000000};
    vecs[4] = '{32'hff0001fc, 1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 2'b01, 32'h000001fc, 32'hff0001fc};
    vecs[5] = '{32'hff000200, 1'b1, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 32'h00000200, 32'hff000200};
    vecs[6] = '{32'h00000fff, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 32'h01000fff, 32'h00000fff};
    vecs[7] = '{32'h00001000, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 32'h01001000, 32'h00001000};
    vecs[8] = '{32'h00000010, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 32'h01000010, 32'h00000010};

    rst_n           = 1'b0;
    input_cmd_start = 1'b0;
    input_cmd_write = 1'b0;
    input_addr      = 32'h0;
    input_wdata     = 32'h0;
    tgt_cmd_ready   = 2'b11;
    tgt_rdata       = 64'h0;
    tgt_rdata_valid = 2'b00;

    // Reset state.
    #2;
    chk("rst_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("rst_error", {31'd0, output_error}, 32'd0);
    chk("rst_unmapped", {31'd0, output_unmapped_write}, 32'd0);
    chk("rst_rdata", output_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, output_cmd_ready}, 32'd1);

    // Decode table: commands are raised and dropped within one low phase,
    // so no transaction is ever accepted.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      input_addr      = vecs[i].addr;
      input_cmd_start = vecs[i].start;
      input_cmd_write = vecs[i].write;
      tgt_cmd_ready   = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, output_cmd_ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_start", i), {30'd0, tgt_cmd_start}, {30'd0, vecs[i].exp_start});
      chk($sformatf("v%0d_write", i), {30'd0, tgt_cmd_write}, {30'd0, vecs[i].exp_write});
      chk($sformatf("v%0d_addr0", i), tgt_addr[31:0], vecs[i].exp_a0);
      chk($sformatf("v%0d_addr1", i), tgt_addr[63:32], vecs[i].exp_a1);
      chk($sformatf("v%0d_valid", i), {31'd0, output_rdata_valid}, 32'd0);
      input_cmd_start = 1'b0;
    end
    tgt_cmd_ready = 2'b11;

    // Read target 1, data arrives three cycles after accept.
    @(negedge clk);
    input_addr = 32'h00000010; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
    #1;
    chk("rd_accept_ready", {31'd0, output_cmd_ready}, 32'd1);
    chk("rd_tgt_start", {30'd0, tgt_cmd_start}, 32'd2);
    chk("rd_tgt_addr1", tgt_addr[63:32], 32'h00000010);
    @(negedge clk);
    input_cmd_start = 1'b0;
    #1;
    chk("rd_t1_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("rd_t1_ready", {31'd0, output_cmd_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("rd_t2_valid", {31'd0, output_rdata_valid}, 32'd0);
    @(negedge clk);
    tgt_rdata[63:32] = 32'h12345678; tgt_rdata_valid = 2'b10;
    #1;
    chk("rd_t3_valid", {31'd0, output_rdata_valid}, 32'd1);
    chk("rd_t3_data", output_rdata, 32'h12345678);
    chk("rd_t3_error", {31'd0, output_error}, 32'd0);
    @(negedge clk);
    tgt_rdata_valid = 2'b00;
    #1;
    chk("rd_t4_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("rd_t4_ready", {31'd0, output_cmd_ready}, 32'd1);

    // Back-to-back writes on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      input_cmd_start = 1'b1; input_cmd_write = 1'b1;
      input_addr  = (i == 2) ? 32'h00000020 : 32'hff000004 + 32'(4 * i);
      input_wdata = 32'h00000041 + 32'(i);
      #1;
      chk($sformatf("wr%0d_ready", i), {31'd0, output_cmd_ready}, 32'd1);
      chk($sformatf("wr%0d_start", i), {30'd0, tgt_cmd_start}, (i == 2) ? 32'd2 : 32'd1);
      chk($sformatf("wr%0d_wflag", i), {30'd0, tgt_cmd_write}, (i == 2) ? 32'd2 : 32'd1);
      chk($sformatf("wr%0d_wdata", i), tgt_wdata, 32'h00000041 + 32'(i));
      chk($sformatf("wr%0d_valid", i), {31'd0, output_rdata_valid}, 32'd0);
    end
    chk("wr0_addr0_last", tgt_addr[63:32], 32'h00000020);
    @(negedge clk);
    input_cmd_start = 1'b0;
    #1;
    chk("wr_after_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("wr_after_ready", {31'd0, output_cmd_ready}, 32'd1);
    chk("wr_after_unmapped", {31'd0, output_unmapped_write}, 32'd0);

    // Unmapped read: error reply next cycle, ready the cycle after.
    @(negedge clk);
    input_addr = 32'h80000000; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
    #1;
    chk("ur_ready", {31'd0, output_cmd_ready}, 32'd1);
    chk("ur_tgt_start", {30'd0, tgt_cmd_start}, 32'd0);
    @(negedge clk);
    input_cmd_start = 1'b0;
    #1;
    chk("ur_valid", {31'd0, output_rdata_valid}, 32'd1);
    chk("ur_error", {31'd0, output_error}, 32'd1);
    chk("ur_data", output_rdata, 32'hdeadbeef);
    chk("ur_busy_ready", {31'd0, output_cmd_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("ur_after_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("ur_after_ready", {31'd0, output_cmd_ready}, 32'd1);

    // Unmapped write: dropped, pulse next cycle.
    @(negedge clk);
    input_cmd_write = 1'b1; input_cmd_start = 1'b1;
    #1;
    chk("uw_tgt_start", {30'd0, tgt_cmd_start}, 32'd0);
    @(negedge clk);
    input_cmd_start = 1'b0;
    #1;
    chk("uw_pulse", {31'd0, output_unmapped_write}, 32'd1);
    chk("uw_valid", {31'd0, output_rdata_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("uw_pulse_end", {31'd0, output_unmapped_write}, 32'd0);

    // Timeout: target 1 never answers, TIMEOUT=4 -> error at T+5.
    @(negedge clk);
    input_addr = 32'h00000010; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      input_cmd_start = 1'b0;
      #1;
      chk($sformatf("to_t%0d_valid", c), {31'd0, output_rdata_valid}, 32'd0);
      chk($sformatf("to_t%0d_ready", c), {31'd0, output_cmd_ready}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("to_t5_valid", {31'd0, output_rdata_valid}, 32'd1);
    chk("to_t5_error", {31'd0, output_error}, 32'd1);
    chk("to_t5_data", output_rdata, 32'hdeadbeef);
    chk("to_t5_ready", {31'd0, output_cmd_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("to_t6_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("to_t6_ready", {31'd0, output_cmd_ready}, 32'd1);

    // Foreign-target valid and address change during BUSY are ignored.
    @(negedge clk);
    input_addr = 32'h00000010; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
    @(negedge clk);
    input_cmd_start = 1'b0; input_addr = 32'hff000004;
    tgt_rdata[31:0] = 32'hcafef00d; tgt_rdata_valid = 2'b01;
    #1;
    chk("fv_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("fv_tgt_start", {30'd0, tgt_cmd_start}, 32'd0);
    @(negedge clk);
    tgt_rdata[63:32] = 32'ha5a55a5a; tgt_rdata_valid = 2'b10;
    #1;
    chk("fv_cur_valid", {31'd0, output_rdata_valid}, 32'd1);
    chk("fv_cur_data", output_rdata, 32'ha5a55a5a);
    chk("fv_cur_error", {31'd0, output_error}, 32'd0);
    @(negedge clk);
    tgt_rdata_valid = 2'b11;
    #1;
    chk("idle_stray_valid", {31'd0, output_rdata_valid}, 32'd0);
    tgt_rdata_valid = 2'b00;

    // Reset while BUSY: pending read dropped.
    @(negedge clk);
    input_addr = 32'h00000010; input_cmd_write = 1'b0; input_cmd_start = 1'b1;
    @(negedge clk);
    input_cmd_start = 1'b0;
    #1;
    chk("rb_busy_ready", {31'd0, output_cmd_ready}, 32'd0);
    rst_n = 1'b0; tgt_rdata_valid = 2'b10; tgt_rdata[63:32] = 32'h0badf00d;
    #1;
    chk("rb_valid", {31'd0, output_rdata_valid}, 32'd0);
    chk("rb_error", {31'd0, output_error}, 32'd0);
    chk("rb_rdata", output_rdata, 32'd0);
    chk("rb_unmapped", {31'd0, output_unmapped_write}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; tgt_rdata_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rb_post%0d_ready", c), {31'd0, output_cmd_ready}, 32'd1);
      chk($sformatf("rb_post%0d_valid", c), {31'd0, output_rdata_valid}, 32'd0);
      @(negedge clk);
    end
    tgt_rdata_valid = 2'b10;
    #1;
    chk("rb_stray_valid", {31'd0, output_rdata_valid}, 32'd0);
    tgt_rdata_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
